// File: rtl/ram32x16_pkg.sv
// Shared widths, depth and FSM encoding for the RAM32X16S burst initiator.
package ram32x16_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

endpackage

// File: rtl/ram32x16_burst_master.sv
// Burst initiator owning the address/data/write-enable pins of a sibling RAM32X16S.
// Accepts one burst command at a time and streams beats with valid/ready handshakes.
module ram32x16_burst_master #(
  parameter int DATA_W = ram32x16_pkg::DATA_W,
  parameter int ADDR_W = ram32x16_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              burst_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_d,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_o
);

  import ram32x16_pkg::*;

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              cmd_fire;
  logic              wr_fire;
  logic              capture;
  logic              beat;
  logic              last_beat;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_fire) state_d = cmd_we ? WRITE : READ;
      WRITE:   if (wr_fire && last_beat) state_d = IDLE;
      READ:    if (capture && last_beat) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Every strobe is qualified by rst_n so a held reset can never write the RAM.
  always_comb begin
    cmd_ready = 1'b0;
    wr_ready  = 1'b0;
    ram_we    = 1'b0;
    ram_d     = '0;
    capture   = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = rst_n;
      end
      WRITE: begin
        wr_ready = rst_n;
        ram_we   = rst_n & wr_valid;
        ram_d    = wr_data;
      end
      READ: begin
        capture = rst_n & (~rd_valid | rd_ready);
      end
      default: begin
        cmd_ready = 1'b0;
      end
    endcase
  end

  assign cmd_fire  = cmd_valid & cmd_ready;
  assign wr_fire   = ram_we;
  assign beat      = wr_fire | capture;
  assign last_beat = (cnt_q == '0);
  assign ram_addr  = addr_q;

  // The read output register lives outside the FSM so a held final beat survives into IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q     <= '0;
      cnt_q      <= '0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      burst_done <= 1'b0;
    end else begin
      burst_done <= beat & last_beat;
      if (cmd_fire) begin
        addr_q <= cmd_addr;
        cnt_q  <= cmd_len;
      end else if (beat) begin
        addr_q <= addr_q + ADDR_W'(1);
        cnt_q  <= cnt_q - ADDR_W'(1);
      end
      if (capture) begin
        rd_data  <= ram_o;
        rd_valid <= 1'b1;
      end else if (rd_ready) begin
        rd_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ram32x16_burst_master.sv
// Bench for ram32x16_burst_master: a behavioural RAM32X16S sits beside the DUT and
// a reference memory image predicts every read beat and write strobe.
module tb_ram32x16_burst_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [4:0]  cmd_addr;
  logic [4:0]  cmd_len;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_data;
  logic        rd_valid;
  logic        rd_ready;
  logic [15:0] rd_data;
  logic        burst_done;
  logic [4:0]  ram_addr;
  logic [15:0] ram_d;
  logic        ram_we;
  logic [15:0] ram_o;

  logic [15:0] mem [32];
  logic [15:0] ref_mem [32];
  logic [15:0] wdata [$];
  int          n_checks = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  ram32x16_burst_master dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_we     (cmd_we),
    .cmd_addr   (cmd_addr),
    .cmd_len    (cmd_len),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_data    (rd_data),
    .burst_done (burst_done),
    .ram_addr   (ram_addr),
    .ram_d      (ram_d),
    .ram_we     (ram_we),
    .ram_o      (ram_o)
  );

  // Sibling RAM: synchronous write, asynchronous read, no reset.
  assign ram_o = mem[ram_addr];
  always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_d;

  task automatic write_burst(input logic [4:0] a, input logic [4:0] len,
                             input int stall_mode, input bit hold_cmd);
    int i = 0;
    int k = 0;
    logic [4:0] ea;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = a; cmd_len = len;
    #1;
    n_checks++;
    if (cmd_ready !== 1'b1) $display("[TB] FAIL wr_cmd_ready: got %b expected 1", cmd_ready); else n_pass++;
    @(posedge clk);
    while (i <= int'(len) && k < 200) begin
      @(negedge clk);
      cmd_valid = hold_cmd; cmd_we = 1'b0; cmd_addr = ~a;
      case (stall_mode)
        0:       wr_valid = 1'b1;
        1:       wr_valid = (k % 2 == 1);
        default: wr_valid = ($urandom_range(0, 3) != 0);
      endcase
      wr_data = wdata[i];
      #1;
      n_checks++;
      if (wr_ready !== 1'b1 || cmd_ready !== 1'b0 || burst_done !== 1'b0)
        $display("[TB] FAIL wr_beat_hs: got wr_ready=%b cmd_ready=%b done=%b expected 1/0/0", wr_ready, cmd_ready, burst_done);
      else n_pass++;
      n_checks++;
      if (ram_we !== wr_valid) $display("[TB] FAIL wr_we_follow: got %b expected %b", ram_we, wr_valid); else n_pass++;
      if (wr_valid) begin
        ea = 5'(int'(a) + i);
        n_checks++;
        if (ram_addr !== ea || ram_d !== wdata[i])
          $display("[TB] FAIL wr_beat_%0d: got addr=%0d d=%h expected addr=%0d d=%h", i, ram_addr, ram_d, ea, wdata[i]);
        else n_pass++;
        ref_mem[ea] = wdata[i];
        i++;
      end
      k++;
    end
    n_checks++;
    if (k >= 200) $display("[TB] FAIL wr_timeout: got %0d beats expected %0d", i, int'(len) + 1); else n_pass++;
    @(negedge clk);
    cmd_valid = 1'b0; wr_valid = 1'b1; wr_data = 16'hDEAD;
    #1;
    n_checks++;
    if (burst_done !== 1'b1 || cmd_ready !== 1'b1 || wr_ready !== 1'b0 || ram_we !== 1'b0 || ram_d !== 16'h0)
      $display("[TB] FAIL wr_done: got done=%b cmd_ready=%b wr_ready=%b we=%b d=%h expected 1/1/0/0/0000",
               burst_done, cmd_ready, wr_ready, ram_we, ram_d);
    else n_pass++;
    @(negedge clk);
    wr_valid = 1'b0;
    #1;
    n_checks++;
    if (burst_done !== 1'b0) $display("[TB] FAIL wr_done_pulse: got %b expected 0", burst_done); else n_pass++;
  endtask

  task automatic read_burst(input logic [4:0] a, input logic [4:0] len, input int ready_mode);
    int got = 0;
    int k = 0;
    bit last_seen = 0;
    logic exp_done;
    logic [4:0] ea;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = a; cmd_len = len; rd_ready = 1'b1;
    #1;
    n_checks++;
    if (cmd_ready !== 1'b1) $display("[TB] FAIL rd_cmd_ready: got %b expected 1", cmd_ready); else n_pass++;
    @(posedge clk);
    while (got <= int'(len) && k < 300) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      case (ready_mode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = (k % 3 == 0);
        default: rd_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      exp_done = rd_valid && (got == int'(len)) && !last_seen;
      n_checks++;
      if (burst_done !== exp_done) $display("[TB] FAIL rd_done_k%0d: got %b expected %b", k, burst_done, exp_done); else n_pass++;
      if (ready_mode == 0) begin
        n_checks++;
        if (rd_valid !== (k >= 1)) $display("[TB] FAIL rd_valid_k%0d: got %b expected %b", k, rd_valid, (k >= 1)); else n_pass++;
      end
      if (rd_valid) begin
        ea = 5'(int'(a) + got);
        n_checks++;
        if (rd_data !== ref_mem[ea])
          $display("[TB] FAIL rd_beat_%0d: got %h expected %h (addr %0d)", got, rd_data, ref_mem[ea], ea);
        else n_pass++;
        if (got == int'(len)) last_seen = 1;
        if (rd_ready) got++;
      end
      k++;
    end
    n_checks++;
    if (k >= 300) $display("[TB] FAIL rd_timeout: got %0d beats expected %0d", got, int'(len) + 1); else n_pass++;
    @(negedge clk);
    rd_ready = 1'b0;
    #1;
    n_checks++;
    if (rd_valid !== 1'b0 || burst_done !== 1'b0)
      $display("[TB] FAIL rd_drain: got valid=%b done=%b expected 0/0", rd_valid, burst_done);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 5'd3; cmd_len = 5'd2;
    wr_valid = 1'b1; wr_data = 16'h1234; rd_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if (cmd_ready !== 1'b0 || wr_ready !== 1'b0 || ram_we !== 1'b0)
      $display("[TB] FAIL reset_strobes: got cmd_ready=%b wr_ready=%b we=%b expected 0/0/0", cmd_ready, wr_ready, ram_we);
    else n_pass++;
    n_checks++;
    if (rd_valid !== 1'b0 || rd_data !== 16'h0 || burst_done !== 1'b0 || ram_addr !== 5'd0 || ram_d !== 16'h0)
      $display("[TB] FAIL reset_regs: got valid=%b data=%h done=%b addr=%0d d=%h expected 0/0000/0/0/0000",
               rd_valid, rd_data, burst_done, ram_addr, ram_d);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1; cmd_valid = 1'b0; wr_valid = 1'b0;
    #1;
    n_checks++;
    if (cmd_ready !== 1'b1) $display("[TB] FAIL reset_release: got %b expected 1", cmd_ready); else n_pass++;
  endtask

  task automatic test_basic();
    wdata = '{16'h0000, 16'h0001, 16'h0010, 16'h0006, 16'h0012};
    write_burst(5'd0, 5'd4, 0, 1'b0);
    read_burst(5'd0, 5'd4, 0);
  endtask

  task automatic test_wrap();
    wdata = '{16'h00A0, 16'h00A1, 16'h00A2, 16'h00A3};
    write_burst(5'd30, 5'd3, 0, 1'b0);
    read_burst(5'd30, 5'd3, 0);
  endtask

  task automatic test_backpressure();
    read_burst(5'd0, 5'd3, 1);
  endtask

  task automatic test_write_stall();
    wdata.delete();
    for (int i = 0; i < 4; i++) wdata.push_back(16'($urandom));
    write_burst(5'd8, 5'd3, 1, 1'b0);
    read_burst(5'd8, 5'd3, 0);
  endtask

  task automatic test_full_depth();
    wdata.delete();
    for (int i = 0; i < 32; i++) wdata.push_back(16'((5 + i) % 32) ^ 16'hFFFF);
    write_burst(5'd5, 5'd31, 0, 1'b1);
    read_burst(5'd5, 5'd31, 0);
    read_burst(5'd17, 5'd31, 2);
  endtask

  task automatic test_reset_mid_write();
    wdata.delete();
    for (int i = 0; i < 8; i++) wdata.push_back(16'($urandom));
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 5'd12; cmd_len = 5'd7;
    @(posedge clk);
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      cmd_valid = 1'b0; wr_valid = 1'b1; wr_data = wdata[b];
      ref_mem[5'(12 + b)] = wdata[b];
      #1;
      n_checks++;
      if (ram_we !== 1'b1) $display("[TB] FAIL rstw_beat_%0d: got we=%b expected 1", b, ram_we); else n_pass++;
    end
    @(negedge clk);
    rst_n = 1'b0; wr_valid = 1'b1; wr_data = 16'hBEEF;
    #1;
    n_checks++;
    if (ram_we !== 1'b0 || wr_ready !== 1'b0 || cmd_ready !== 1'b0)
      $display("[TB] FAIL rstw_gate: got we=%b wr_ready=%b cmd_ready=%b expected 0/0/0", ram_we, wr_ready, cmd_ready);
    else n_pass++;
    repeat (2) begin
      @(negedge clk);
      #1;
      n_checks++;
      if (ram_we !== 1'b0 || burst_done !== 1'b0)
        $display("[TB] FAIL rstw_hold: got we=%b done=%b expected 0/0", ram_we, burst_done);
      else n_pass++;
    end
    @(negedge clk);
    rst_n = 1'b1; wr_valid = 1'b0;
    #1;
    n_checks++;
    if (cmd_ready !== 1'b1 || burst_done !== 1'b0)
      $display("[TB] FAIL rstw_release: got cmd_ready=%b done=%b expected 1/0", cmd_ready, burst_done);
    else n_pass++;
    @(negedge clk);
    #1;
    n_checks++;
    if (burst_done !== 1'b0) $display("[TB] FAIL rstw_no_done: got %b expected 0", burst_done); else n_pass++;
    read_burst(5'd12, 5'd7, 0);
  endtask

  task automatic test_reset_read();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 5'd0; cmd_len = 5'd2; rd_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (rd_valid !== 1'b1 || rd_data !== ref_mem[0])
      $display("[TB] FAIL rstr_held: got valid=%b data=%h expected 1/%h", rd_valid, rd_data, ref_mem[0]);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    n_checks++;
    if (rd_valid !== 1'b0 || burst_done !== 1'b0)
      $display("[TB] FAIL rstr_drop: got valid=%b done=%b expected 0/0", rd_valid, burst_done);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic [4:0] a;
    logic [4:0] len;
    for (int t = 0; t < 8; t++) begin
      a = 5'($urandom);
      len = 5'($urandom);
      wdata.delete();
      for (int i = 0; i <= int'(len); i++) wdata.push_back(16'($urandom));
      write_burst(a, len, 2, 1'($urandom_range(0, 1)));
      read_burst(5'($urandom), 5'($urandom), 2);
      read_burst(a, len, 2);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem[i] = 16'(i * 16'h1111) ^ 16'h5A5A;
      ref_mem[i] = 16'(i * 16'h1111) ^ 16'h5A5A;
    end
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_write_stall();
    test_full_depth();
    test_reset_mid_write();
    test_reset_read();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/ram32x16_burst_master.md
# ram32x16_burst_master

Burst initiator that drives the 32x16 single-port distributed RAM (RAM32X16S: synchronous write, asynchronous read) on behalf of upstream logic. It accepts one burst command at a time, then streams write data into the RAM or streams read data out of it with valid/ready backpressure. The RAM is instantiated beside this block in the parent schematic; this block owns the RAM's address, data-in and write-enable pins.

## Interface
- DATA_W, 16, RAM word width.
- ADDR_W, 5, RAM address width (depth 2**ADDR_W = 32).

Ports:
- clk  in  1  rising-edge clock, shared with the RAM.
- rst_n  in  1  synchronous reset, active-low.
- cmd_valid  in  1  burst command offered.
- cmd_ready  out  1  command accepted this cycle when both high.
- cmd_we  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  ADDR_W  start address.
- cmd_len  in  ADDR_W  burst length minus 1 (0..31 means 1..32 words).
- wr_valid  in  1  write beat offered.
- wr_ready  out  1  write beat accepted when both high.
- wr_data  in  DATA_W  write beat data.
- rd_valid  out  1  read beat available.
- rd_ready  in  1  downstream accepts read beat.
- rd_data  out  DATA_W  read beat data.
- burst_done  out  1  one-cycle pulse after the last beat of a burst.
- ram_addr  out  ADDR_W  to RAM addr4..addr0 (bit 0 = addr0).
- ram_d  out  DATA_W  to RAM D.
- ram_we  out  1  to RAM WEn, active-high.
- ram_o  in  DATA_W  from RAM O (combinational read data).

## Operation
- FSM states: IDLE, WRITE, READ.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready, register addr=cmd_addr, cnt=cmd_len, go to WRITE if cmd_we, else READ.
- WRITE: wr_ready=1; ram_addr=addr; ram_d=wr_data (combinational); ram_we=wr_valid. Each accepted beat advances addr by 1 mod 32 and decrements cnt. The beat with cnt==0 returns to IDLE and pulses burst_done on the next cycle.
- READ: ram_we=0; ram_addr=addr. When rd_valid==0 or rd_ready==1, capture ram_o into rd_data, set rd_valid, and advance addr/cnt. The capture with cnt==0 returns to IDLE and pulses burst_done. rd_valid clears on rd_ready when no new capture happens.
- The rd_data/rd_valid output register runs independently of the FSM. A pending final read beat may still be held in IDLE, and a new command may be accepted meanwhile.
- Address wrap: 31+1 = 0 within a burst. A 32-word burst starting at any address covers every location exactly once.
- Outside WRITE, ram_d=0 and wr_ready=0. Outside READ, no capture occurs.
- ram_we is gated by rst_n, so no RAM write can occur while rst_n=0.

## Timing
- Reset (rst_n low at a rising edge): state=IDLE, addr=0, cnt=0, rd_valid=0, rd_data=0, burst_done=0. While rst_n=0, ram_we=0, wr_ready=0 and cmd_ready=0. Once rst_n is high, cmd_ready=1.
- Reset mid-burst aborts the burst with no further RAM writes and no burst_done. A pending rd_valid is dropped. RAM contents are untouched because the RAM has no reset.
- Write latency: a word is in the RAM at the rising edge where wr_valid&wr_ready. It is readable at the next read of that address.
- Read latency: rd_valid rises 1 cycle after entering READ. Without backpressure, the burst delivers 1 beat per cycle and N beats take N cycles.
- Command turnaround: 1 IDLE cycle between bursts. Command accept to first write beat takes 1 cycle.
- burst_done is high for exactly 1 cycle, in the first IDLE cycle after the burst.
- cmd_valid is ignored outside IDLE. wr_valid is ignored outside WRITE.

## Structure
- Shared package ram32x16_pkg holds DATA_W/ADDR_W defaults, DEPTH=32, and the state encoding IDLE=2'd0, WRITE=2'd1, READ=2'd2.
- No sub-module. The FSM, address counter and read output register live in one module. The RAM is a sibling instance in the parent.

## Test plan
- Reset, then write burst addr=0, len=4, data 0x0,0x1,0x10,0x6,0x12 -> ram_we is high 5 cycles at addresses 0..4, followed by one burst_done pulse. A read burst addr=0, len=4 then returns 0x0,0x1,0x10,0x6,0x12 with rd_valid high 5 consecutive cycles.
- Wrap: write addr=30, len=3, data 0xA0..0xA3 -> locations 30,31,0,1 are written. Read addr=30, len=3 returns 0xA0,0xA1,0xA2,0xA3.
- Backpressure: read len=3 with rd_ready toggling 1,0,0,1,... -> no beat is lost or duplicated, rd_data is stable while rd_valid=1 and rd_ready=0, and burst_done follows the 4th capture.
- Write stalls: wr_valid low on alternate cycles during len=3 -> ram_we follows wr_valid exactly, and the final contents are correct.
- Full depth: write 32 words (addr=5, len=31, data=address^0xFFFF), then read back all 32 -> every word matches. The command is ignored while the burst is active.
- Reset mid-write after 2 beats of len=7 -> ram_we=0 from the reset edge onward, and no burst_done. Only the first 2 locations change, and cmd_ready=1 after reset.
